branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 64, number of predictor entries (power of two, at least 4); IDX_W = log2(NUM_ENTRIES).
REQ-002 SHALL have parameter TAG_W, default 16, number of PC tag bits stored per BTB entry.
REQ-003 SHALL have ports, in this order:
- clk_i  in  1  clock; single clock domain, all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  request to re-initialise all tables.
- pc_fetch_i  in  addrPC_t  fetch PC to predict.
- pred_taken_o  out  branch_decision_t  predicted direction for pc_fetch_i.
- pred_target_o  out  addrPC_t  predicted target for pc_fetch_i.
- ready_o  out  1  tables initialised; predictions and updates honoured.
- upd_valid_i  in  1  a resolved branch from exe is presented this cycle.
- upd_pc_i  in  addrPC_t  PC of the resolved branch.
- upd_taken_i  in  branch_decision_t  resolved direction.
- upd_target_i  in  addrPC_t  resolved target.

Function
REQ-004 SHALL compute index = pc[IDX_W+1:2] and tag = pc[IDX_W+TAG_W+1:IDX_W+2] for both pc_fetch_i and upd_pc_i.
REQ-005 SHALL hold per entry: a 2-bit saturating counter, a BTB valid bit, a TAG_W-bit tag and an addrPC_t target.
REQ-006 SHALL use an FSM with states INIT and RUN.
REQ-007 In INIT, SHALL use an index counter that starts at 0 and clears one entry per cycle: valid=0, counter=2'b01 (weakly not-taken).
REQ-008 SHALL leave INIT for RUN on the cycle after entry NUM_ENTRIES-1 is cleared, so INIT lasts exactly NUM_ENTRIES cycles.
REQ-009 SHALL drive ready_o=1 only in RUN.
REQ-010 In INIT, SHALL drive pred_taken_o=NOT_TAKEN and pred_target_o=0, and SHALL ignore upd_valid_i.
REQ-011 Prediction SHALL be combinational from the current table state (zero latency).
REQ-012 Prediction: pred_taken_o=TAKEN iff counter[1]=1, valid=1 and the stored tag equals the fetch tag; pred_target_o = stored target when TAKEN, else pc_fetch_i+4.
REQ-013 Update SHALL take effect at the rising edge of a RUN cycle with upd_valid_i=1.
REQ-014 On an update with upd_taken_i=TAKEN, SHALL increment the counter (saturating at 2'b11) and write valid=1, tag and upd_target_i.
REQ-015 On an update with upd_taken_i=NOT_TAKEN, SHALL decrement the counter (saturating at 2'b00) and leave the BTB fields unchanged.
REQ-016 A taken update with a tag mismatch SHALL overwrite the tag and target and still increment the existing counter (no counter reset on replacement).
REQ-017 When a lookup and an update hit the same index in the same cycle, the prediction SHALL reflect the pre-update state (no bypass).
REQ-018 When flush_i=1 in RUN and the flush feature is compiled in, SHALL enter INIT next cycle with the index counter at 0 and discard any same-cycle update.
REQ-019 flush_i asserted during INIT SHALL NOT restart the sweep.
REQ-020 PC arithmetic SHALL be modulo the addrPC_t width (pc+4 wraps).

Reset
REQ-021 rst_i=1 at a rising edge SHALL force state INIT and index counter 0, including mid-INIT or mid-update; the table contents need not be reset directly.
REQ-022 While rst_i=1 and on the first cycle after reset, outputs SHALL be ready_o=0, pred_taken_o=NOT_TAKEN and pred_target_o=0.

Configuration
REQ-023 With macro BPRED_FLUSH_EN defined, flush_i SHALL behave per REQ-018.
REQ-024 With BPRED_FLUSH_EN undefined, the flush_i port SHALL remain but be ignored, and INIT SHALL be entered only via rst_i.

Verification
REQ-025 Release reset with NUM_ENTRIES=64 -> ready_o=0 for 64 cycles and 1 from cycle 64; every index predicts NOT_TAKEN with target pc+4.
REQ-026 Update pc=0x1000, TAKEN, target 0x2000, once -> counter 2'b10; lookup 0x1000 gives TAKEN/0x2000; lookup 0x1100 (same index, different tag) gives NOT_TAKEN/0x1104.
REQ-027 Three TAKEN updates then three NOT_TAKEN updates on pc=0x40 -> counter sequence 01,10,11,11,10,01,00; prediction TAKEN after the first and second TAKEN updates and after the first NOT_TAKEN update, NOT_TAKEN after the remaining two.
REQ-028 Lookup and TAKEN update on pc=0x80 in the same cycle -> NOT_TAKEN that cycle, TAKEN the next cycle.
REQ-029 flush_i=1 together with upd_valid_i=1 in RUN (BPRED_FLUSH_EN defined) -> update dropped, ready_o=0 for 64 cycles, all entries cleared; with the macro undefined -> update applied and ready_o stays 1.
REQ-030 rst_i=1 at INIT index 30 -> sweep restarts at 0 and ready_o rises 64 cycles after rst_i deasserts.

Source files
------------

// File: rtl/branch_predictor.sv
// Bimodal direction predictor with a direct-mapped BTB; tables are swept clean on reset.
// Optional macro BPRED_FLUSH_EN lets flush_i restart the sweep from RUN.
module branch_predictor #(
    parameter int unsigned NUM_ENTRIES = 64,
    parameter int unsigned TAG_W = 16,
    parameter type addrPC_t = logic [31:0],
    parameter type branch_decision_t = logic
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  addrPC_t          pc_fetch_i,
    output branch_decision_t pred_taken_o,
    output addrPC_t          pred_target_o,
    output logic             ready_o,
    input  logic             upd_valid_i,
    input  addrPC_t          upd_pc_i,
    input  branch_decision_t upd_taken_i,
    input  addrPC_t          upd_target_i
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam branch_decision_t TAKEN = branch_decision_t'(1'b1);
    localparam branch_decision_t NOT_TAKEN = branch_decision_t'(1'b0);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               init_we, upd_we;

    logic [1:0]         cnt_q   [NUM_ENTRIES];
    logic               valid_q [NUM_ENTRIES];
    logic [TAG_W-1:0]   tag_q   [NUM_ENTRIES];
    addrPC_t            tgt_q   [NUM_ENTRIES];

    logic [IDX_W-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0]   f_tag, u_tag;
    logic               f_hit;
    logic [1:0]         cnt_upd;

    assign f_idx = pc_fetch_i[IDX_W+1:2];
    assign f_tag = pc_fetch_i[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = upd_pc_i[IDX_W+1:2];
    assign u_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Low alignment bits and PC bits above the tag do not take part in lookup.
    logic unused_pc;
    assign unused_pc = ^{pc_fetch_i, upd_pc_i};
`ifndef BPRED_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush_i;
`endif

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && cnt_q[f_idx][1];

    always_comb begin
        cnt_upd = cnt_q[u_idx];
        if (upd_taken_i == TAKEN) begin
            if (cnt_q[u_idx] != 2'b11) cnt_upd = cnt_q[u_idx] + 2'b01;
        end else begin
            if (cnt_q[u_idx] != 2'b00) cnt_upd = cnt_q[u_idx] - 2'b01;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        init_we       = 1'b0;
        upd_we        = 1'b0;
        ready_o       = 1'b0;
        pred_taken_o  = NOT_TAKEN;
        pred_target_o = '0;
        unique case (state_q)
            StInit: begin
                init_we = 1'b1;
                if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_d = StRun;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StRun: begin
                ready_o       = 1'b1;
                pred_taken_o  = f_hit ? TAKEN : NOT_TAKEN;
                pred_target_o = f_hit ? tgt_q[f_idx] : pc_fetch_i + addrPC_t'(4);
                upd_we        = upd_valid_i;
`ifdef BPRED_FLUSH_EN
                if (flush_i) begin
                    state_d = StInit;
                    idx_d   = '0;
                    upd_we  = 1'b0;
                end
`endif
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StInit;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Table storage is not reset; the INIT sweep is what makes it valid.
    always_ff @(posedge clk_i) begin
        if (init_we) begin
            cnt_q[idx_q]   <= 2'b01;
            valid_q[idx_q] <= 1'b0;
        end else if (upd_we) begin
            cnt_q[u_idx] <= cnt_upd;
            if (upd_taken_i == TAKEN) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                tgt_q[u_idx]   <= upd_target_i;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a table-level model predicts each cycle's outputs,
// a negedge monitor pops and compares them.
module tb_branch_predictor;

    localparam int N = 64;
    localparam int IDX_W = 6;
    localparam int TAG_W = 16;
`ifdef BPRED_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, upd_valid, upd_taken, pred_taken, ready;
    logic [31:0] pc_fetch, upd_pc, upd_target, pred_target;

    branch_predictor #(
        .NUM_ENTRIES(N),
        .TAG_W(TAG_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .pc_fetch_i(pc_fetch),
        .pred_taken_o(pred_taken),
        .pred_target_o(pred_target),
        .ready_o(ready),
        .upd_valid_i(upd_valid),
        .upd_pc_i(upd_pc),
        .upd_taken_i(upd_taken),
        .upd_target_i(upd_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ready;
        bit          taken;
        logic [31:0] target;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;

    // Reference model: counter as an integer 0..3, BTB fields per entry, INIT as cycles left.
    int          m_cnt[N];
    bit          m_val[N];
    logic [15:0] m_tag[N];
    logic [31:0] m_tgt[N];
    int          init_left = N;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [15:0] tag_of(input logic [31:0] pc);
        return 16'(pc >> (IDX_W + 2));
    endfunction

    function automatic logic [31:0] rpc();
        logic [31:0] v;
        if ($urandom_range(0, 30) == 0) return 32'hFFFF_FFFC;
        v = (32'($urandom_range(0, 1)) << (IDX_W + 2)) | (32'($urandom_range(0, 7)) << 2);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s cyc %0d: got %h expected %h", nm, cyc, act, exp_v);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".ready"}, 32'(ready), 32'(e.ready));
            check({e.name, ".taken"}, 32'(pred_taken), 32'(e.taken));
            check({e.name, ".target"}, pred_target, e.target);
        end
    end

    task automatic step(input bit r, input bit f, input logic [31:0] fpc, input bit uv,
                        input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                        input string nm, input bit chk = 1'b1);
        exp_t e;
        int   i;
        rst = r; flush = f; pc_fetch = fpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        e.name = nm;
        e.ready = (init_left == 0);
        e.taken = 1'b0;
        e.target = 32'h0;
        if (e.ready) begin
            i = idx_of(fpc);
            e.taken = m_val[i] && (m_tag[i] == tag_of(fpc)) && (m_cnt[i] >= 2);
            e.target = e.taken ? m_tgt[i] : fpc + 32'd4;
        end
        if (chk) sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            init_left = N;
        end else if (init_left > 0) begin
            m_val[N - init_left] = 1'b0;
            m_cnt[N - init_left] = 1;
            init_left--;
        end else if (f && FLUSH_EN) begin
            init_left = N;
        end else if (uv) begin
            i = idx_of(upc);
            if (ut) begin
                m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                m_val[i] = 1'b1;
                m_tag[i] = tag_of(upc);
                m_tgt[i] = utg;
            end else begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
        end
    endtask

    task automatic idle(input logic [31:0] fpc, input string nm);
        step(1'b0, 1'b0, fpc, 1'b0, 32'h0, 1'b0, 32'h0, nm);
    endtask

    task automatic rnd(input int n, input string nm, input int rare);
        for (int k = 0; k < n; k++) begin
            step(rare != 0 && $urandom_range(0, rare) == 0,
                 rare != 0 && $urandom_range(0, rare) == 0,
                 rpc(), $urandom_range(0, 1) == 1, rpc(), $urandom_range(0, 1) == 1,
                 $urandom(), nm);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pc_fetch = '0; upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "pre", 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, rpc(), 1'b1, rpc(), 1'b1, 32'h1234, "rst");

        // INIT sweep with updates presented that must be ignored
        rnd(N + 2, "init", 0);
        for (int i = 0; i < N; i++) idle(32'(i << 2) | 32'h0003_0000, "clean");

        step(1'b0, 1'b0, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h2000, "btb_upd");
        idle(32'h1000, "btb_hit");
        idle(32'h1100, "btb_tagmiss");

        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h400, "sat_t");
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, "sat_nt");
        idle(32'h40, "sat_end");

        step(1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h880, "bypass");
        idle(32'h80, "bypass_next");

        idle(32'hFFFF_FFFC, "wrap");

        step(1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h999, "flush");
        for (int k = 0; k < N + 2; k++) idle(32'h200, "post_flush");
        idle(32'h1000, "post_flush_btb");

        // Reset landing mid-sweep at index 30
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "rst30_a");
        rnd(30, "rst30_sweep", 0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "rst30_b");
        rnd(N + 2, "rst30_restart", 0);

        rnd(3000, "random", 150);

        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
